// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, instruction field layout and decode helper.
// Used by the issue stage and the ALU pipeline.
package alu_pkg;

    localparam int unsigned INSTR_W = 24;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned FUNC_W  = 4;

    localparam int unsigned FUNC_LSB = 20;
    localparam int unsigned RD_LSB   = 16;
    localparam int unsigned RS1_LSB  = 12;
    localparam int unsigned RS2_LSB  = 8;
    localparam int unsigned ADDR_LSB = 0;

    localparam logic [FUNC_W-1:0] ADD  = 4'd0;
    localparam logic [FUNC_W-1:0] SUB  = 4'd1;
    localparam logic [FUNC_W-1:0] AND  = 4'd2;
    localparam logic [FUNC_W-1:0] OR   = 4'd3;
    localparam logic [FUNC_W-1:0] XOR  = 4'd4;
    localparam logic [FUNC_W-1:0] NOR  = 4'd5;
    localparam logic [FUNC_W-1:0] SLT  = 4'd6;
    localparam logic [FUNC_W-1:0] SLTU = 4'd7;
    localparam logic [FUNC_W-1:0] SHR  = 4'd8;
    localparam logic [FUNC_W-1:0] SRA  = 4'd9;
    localparam logic [FUNC_W-1:0] MUL  = 4'd10;
    localparam logic [FUNC_W-1:0] SHL  = 4'd11;
    localparam logic [FUNC_W-1:0] FUNC_MAX = SHL;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] w);
        instr_t d;
        d.func = w[FUNC_LSB +: FUNC_W];
        d.rd   = w[RD_LSB   +: REG_W];
        d.rs1  = w[RS1_LSB  +: REG_W];
        d.rs2  = w[RS2_LSB  +: REG_W];
        d.addr = w[ADDR_LSB +: ADDR_W];
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream instruction handshake plus decoded issue slot toward the ALU.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic                 in_valid;
    logic [INSTR_W-1:0]   in_instr;
    logic                 in_ready;
    logic                 iss_valid;
    logic [REG_W-1:0]     iss_rs1;
    logic [REG_W-1:0]     iss_rs2;
    logic [REG_W-1:0]     iss_rd;
    logic [FUNC_W-1:0]    iss_func;
    logic [ADDR_W-1:0]    iss_addr;
    logic                 illegal;

    modport master (
        output in_valid, in_instr,
        input  in_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr, illegal
    );

    modport slave (
        input  in_valid, in_instr,
        output in_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr, illegal
    );

endinterface

// File: rtl/alu_scoreboard.sv
// Fixed-latency writeback tracker: a shift register of in-flight destination registers
// compared against the source registers of the word waiting to issue.
module alu_scoreboard
    import alu_pkg::*;
#(
    parameter int unsigned WB_LAT = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push_v,
    input  logic [REG_W-1:0] i_push_rd,
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    output logic             o_hit
);

    logic             r_v  [WB_LAT];
    logic [REG_W-1:0] r_rd [WB_LAT];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < WB_LAT; i++) begin
                r_v[i]  <= 1'b0;
                r_rd[i] <= '0;
            end
        end else begin
            r_v[0]  <= i_push_v;
            r_rd[0] <= i_push_rd;
            for (int unsigned i = 1; i < WB_LAT; i++) begin
                r_v[i]  <= r_v[i-1];
                r_rd[i] <= r_rd[i-1];
            end
        end
    end

    always_comb begin
        o_hit = 1'b0;
        for (int unsigned i = 0; i < WB_LAT; i++) begin
            if (r_v[i] && ((r_rd[i] == i_rs1) || (r_rd[i] == i_rs2))) begin
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: one-entry hold register, RAW hazard stall against the writeback
// scoreboard, illegal-word drop, registered issue slot and saturating event counters.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned WB_LAT = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    alu_issue_stage_if.slave   if_bus,
    output logic [CNT_W-1:0]   o_stall_cnt,
    output logic [7:0]         o_illegal_cnt
);

    logic               r_hold_v;
    logic [INSTR_W-1:0] r_hold_instr;
    logic               r_iss_valid;
    instr_t             r_iss;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [7:0]         r_illegal_cnt;

    instr_t w_hold;
    logic   w_hit;
    logic   w_illegal_now;
    logic   w_hazard;
    logic   w_leave;
    logic   w_issue;
    logic   w_accept;

    assign w_hold        = decode(r_hold_instr);
    assign w_illegal_now = r_hold_v && (w_hold.func > FUNC_MAX);
    assign w_hazard      = r_hold_v && !w_illegal_now && w_hit;
    assign w_leave       = r_hold_v && (w_illegal_now || !w_hazard);
    assign w_issue       = w_leave && !w_illegal_now;
    // Ready looks through a leaving word so a hazard-free stream runs without bubbles.
    assign if_bus.in_ready = !r_hold_v || w_leave;
    assign w_accept      = if_bus.in_valid && if_bus.in_ready;

    alu_scoreboard #(
        .WB_LAT (WB_LAT)
    ) u_scoreboard (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push_v  (w_issue),
        .i_push_rd (w_hold.rd),
        .i_rs1     (w_hold.rs1),
        .i_rs2     (w_hold.rs2),
        .o_hit     (w_hit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold_v     <= 1'b0;
            r_hold_instr <= '0;
        end else if (w_accept) begin
            r_hold_v     <= 1'b1;
            r_hold_instr <= if_bus.in_instr;
        end else if (w_leave) begin
            r_hold_v     <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_iss_valid <= 1'b0;
            r_iss       <= '0;
        end else begin
            r_iss_valid <= w_issue;
            if (w_issue) begin
                r_iss <= w_hold;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_illegal     <= 1'b0;
            r_illegal_cnt <= '0;
            r_stall_cnt   <= '0;
        end else begin
            r_illegal <= w_leave && w_illegal_now;
            if (w_leave && w_illegal_now && (r_illegal_cnt != 8'hFF)) begin
                r_illegal_cnt <= r_illegal_cnt + 8'd1;
            end
            if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign if_bus.iss_valid = r_iss_valid;
    assign if_bus.iss_func  = r_iss.func;
    assign if_bus.iss_rd    = r_iss.rd;
    assign if_bus.iss_rs1   = r_iss.rs1;
    assign if_bus.iss_rs2   = r_iss.rs2;
    assign if_bus.iss_addr  = r_iss.addr;
    assign if_bus.illegal   = r_illegal;
    assign o_stall_cnt      = r_stall_cnt;
    assign o_illegal_cnt    = r_illegal_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Cycle-table bench for alu_issue_stage, plus a stall-counter saturation run on a
// deeper-latency instance.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] stall_cnt;
    logic [7:0]  illegal_cnt;
    logic [15:0] stall8;
    logic [7:0]  illegal8;

    alu_issue_stage_if bus ();
    alu_issue_stage_if bus8 ();

    alu_issue_stage #(
        .WB_LAT (2),
        .CNT_W  (16)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .if_bus        (bus),
        .o_stall_cnt   (stall_cnt),
        .o_illegal_cnt (illegal_cnt)
    );

    alu_issue_stage #(
        .WB_LAT (8),
        .CNT_W  (16)
    ) dut8 (
        .i_clk         (clk),
        .i_rst         (rst),
        .if_bus        (bus8),
        .o_stall_cnt   (stall8),
        .o_illegal_cnt (illegal8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v;
        logic [23:0] w;
        logic        chk;
        logic        rdy;
        logic        iv;
        logic        chkf;
        logic [23:0] f;
        logic        ill;
        int          sc;
        int          ic;
    } vec_t;

    vec_t vecs [64];
    int   n_vec = 0;
    int   total = 0;
    int   bad   = 0;

    function automatic logic [23:0] mk(input int fn, input int rd, input int rs1,
                                       input int rs2, input int addr);
        return {fn[3:0], rd[3:0], rs1[3:0], rs2[3:0], addr[7:0]};
    endfunction

    task automatic add(input logic r, input logic v, input logic [23:0] w, input logic chk,
                       input logic rdy, input logic iv, input logic chkf, input logic [23:0] f,
                       input logic ill, input int sc, input int ic);
        vecs[n_vec] = '{r, v, w, chk, rdy, iv, chkf, f, ill, sc, ic};
        n_vec++;
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%0h expected=%0h", name, row, act, exp);
        end
    endtask

    logic [23:0] i1, i2, i3, a, b, a2, c, d, l1, x, l2, p, q, r, s;
    logic        reached;

    initial begin
        i1 = mk(0, 1, 2, 3, 8'h11);
        i2 = mk(1, 4, 5, 6, 8'h22);
        i3 = mk(4, 7, 8, 9, 8'h33);
        a  = mk(0, 1, 2, 3, 8'h44);
        b  = mk(3, 5, 1, 4, 8'h55);
        a2 = mk(0, 1, 2, 3, 8'h66);
        c  = mk(2, 6, 7, 8, 8'h77);
        d  = mk(1, 9, 1, 2, 8'h88);
        l1 = mk(0, 10, 11, 12, 8'h99);
        x  = mk(13, 2, 3, 4, 8'hAA);
        l2 = mk(4, 3, 2, 14, 8'hBB);
        p  = mk(0, 5, 1, 1, 8'h01);
        q  = mk(1, 6, 5, 0, 8'h02);
        r  = mk(0, 7, 5, 6, 8'h03);
        s  = mk(0, 1, 1, 1, 8'h00);

        //  rst v  word  chk rdy iv chkf fields ill sc ic
        add(1, 0, '0, 0, 0, 0, 0, '0, 0, 0, 0);
        // independent stream
        add(0, 1, i1, 1, 1, 0, 0, '0, 0, 0, 0);
        add(0, 1, i2, 1, 1, 0, 0, '0, 0, 0, 0);
        add(0, 1, i3, 1, 1, 1, 1, i1, 0, 0, 0);
        add(0, 0, '0, 1, 1, 1, 1, i2, 0, 0, 0);
        add(0, 0, '0, 1, 1, 1, 1, i3, 0, 0, 0);
        add(0, 0, '0, 1, 1, 0, 1, i3, 0, 0, 0);
        // RAW at distance 1: two bubbles
        add(0, 1, a,  1, 1, 0, 0, '0, 0, 0, 0);
        add(0, 1, b,  1, 1, 0, 0, '0, 0, 0, 0);
        add(0, 1, b,  1, 0, 1, 1, a,  0, 0, 0);
        add(0, 1, b,  1, 0, 0, 0, '0, 0, 1, 0);
        add(0, 0, '0, 1, 1, 0, 0, '0, 0, 2, 0);
        add(0, 0, '0, 1, 1, 1, 1, b,  0, 2, 0);
        // RAW at distance 2: one bubble
        add(0, 1, a2, 1, 1, 0, 0, '0, 0, 2, 0);
        add(0, 1, c,  1, 1, 0, 0, '0, 0, 2, 0);
        add(0, 1, d,  1, 1, 1, 1, a2, 0, 2, 0);
        add(0, 1, d,  1, 0, 1, 1, c,  0, 2, 0);
        add(0, 0, '0, 1, 1, 0, 0, '0, 0, 3, 0);
        add(0, 0, '0, 1, 1, 1, 1, d,  0, 3, 0);
        // illegal word between two legal ones; its rd must not block l2
        add(0, 1, l1, 1, 1, 0, 0, '0, 0, 3, 0);
        add(0, 1, x,  1, 1, 0, 0, '0, 0, 3, 0);
        add(0, 1, l2, 1, 1, 1, 1, l1, 0, 3, 0);
        add(0, 0, '0, 1, 1, 0, 1, l1, 1, 3, 1);
        add(0, 0, '0, 1, 1, 1, 1, l2, 0, 3, 1);
        add(0, 0, '0, 1, 1, 0, 0, '0, 0, 3, 1);
        // reset in the middle of a stall
        add(0, 1, p,  1, 1, 0, 0, '0, 0, 3, 1);
        add(0, 1, q,  1, 1, 0, 0, '0, 0, 3, 1);
        add(0, 1, q,  1, 0, 1, 1, p,  0, 3, 1);
        add(1, 0, '0, 1, 0, 0, 0, '0, 0, 4, 1);
        add(0, 1, r,  1, 1, 0, 1, '0, 0, 0, 0);
        add(0, 0, '0, 1, 1, 0, 0, '0, 0, 0, 0);
        add(0, 0, '0, 1, 1, 1, 1, r,  0, 0, 0);
        add(0, 0, '0, 1, 1, 0, 0, '0, 0, 0, 0);

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus8.in_valid = 1'b0;
        bus8.in_instr = '0;

        for (int i = 0; i < n_vec; i++) begin
            @(negedge clk);
            if (vecs[i].chk) begin
                chk("in_ready", i, {31'b0, bus.in_ready}, {31'b0, vecs[i].rdy});
                chk("iss_valid", i, {31'b0, bus.iss_valid}, {31'b0, vecs[i].iv});
                chk("illegal", i, {31'b0, bus.illegal}, {31'b0, vecs[i].ill});
                chk("stall_cnt", i, {16'b0, stall_cnt}, vecs[i].sc);
                chk("illegal_cnt", i, {24'b0, illegal_cnt}, vecs[i].ic);
                if (vecs[i].chkf) begin
                    chk("iss_fields", i,
                        {8'b0, bus.iss_func, bus.iss_rd, bus.iss_rs1, bus.iss_rs2, bus.iss_addr},
                        {8'b0, vecs[i].f});
                end
            end
            rst          = vecs[i].rst;
            bus.in_valid = vecs[i].v;
            bus.in_instr = vecs[i].w;
        end

        // Self-dependent word repeated: eight stall cycles per issue until saturation.
        @(negedge clk);
        chk("sat_start", 0, {16'b0, stall8}, 0);
        bus8.in_instr = s;
        bus8.in_valid = 1'b1;
        reached = 1'b0;
        for (int n = 0; n < 80000 && !reached; n++) begin
            @(negedge clk);
            if (stall8 == 16'hFFFF) reached = 1'b1;
        end
        chk("sat_reach", 0, {31'b0, reached}, 32'd1);
        repeat (20) @(negedge clk);
        chk("sat_hold", 0, {16'b0, stall8}, 32'h0000FFFF);
        chk("sat_illegal_cnt", 0, {24'b0, illegal8}, 0);
        bus8.in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Single-clock issue stage that sits directly upstream of the four-stage pipelined ALU. It accepts 24-bit ALU instruction words over a valid/ready handshake and decodes them into the ALU's rs1/rs2/rd/func/addr operand fields. It stalls read-after-write hazards, because the ALU has no forwarding path. Illegal function codes are dropped and counted.

## Interface
- WB_LAT, 2: cycles after an issue before its rd is readable in the register bank; scoreboard depth (1..8)
- CNT_W, 16: width of stall counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  instruction word present
- in_instr  in  24  {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}
- in_ready  out  1  hold register can accept a word this cycle
- iss_valid  out  1  issue slot carries a real instruction
- iss_rs1, iss_rs2, iss_rd, iss_func  out  4 each  decoded fields to ALU
- iss_addr  out  8  memory address to ALU
- illegal  out  1  one-cycle pulse: illegal word dropped
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles
- illegal_cnt  out  8  saturating count of dropped words

## Operation
- Hold register (one entry, hold_v) captures in_instr when in_valid && in_ready.
- in_ready = !hold_v || leave, where leave = hold_v && (illegal_now || !hazard). This is combinational and gives full throughput with no bubble when there is no hazard.
- illegal_now: hold_v && func > 11.
- Illegal path: on a leave, an illegal word is discarded with no issue. The next cycle has illegal=1, iss_valid=0 and illegal_cnt+1 (saturating at 255).
- hazard: hold_v && legal && (rs1 or rs2 equals rd of any valid scoreboard entry).
- A hazard stalls the word in hold; stall_cnt+1 per stalled cycle (saturating).
- Issue: a legal, hazard-free hold word drives iss_* registered at the next edge with iss_valid=1.
- When no issue occurs, iss_valid=0 and the iss_* fields hold their last values.
- Scoreboard: shift register of WB_LAT entries {v, rd} that shifts every cycle.
  - Entry 0 loads {1, rd} on an issue and {0, x} otherwise (bubble).
  - The entry leaving position WB_LAT-1 is retired.
- Only RAW hazards are checked. WAW and WAR are safe because writeback is in-order and fixed-latency.
- rd = rs of the same word is not a hazard.
- Reset, including mid-stall:
  - Clears hold_v, all scoreboard valid bits, iss_valid, illegal, stall_cnt and illegal_cnt.
  - Clears the iss_* fields to 0.
  - in_ready is 1 in the first cycle after reset.
  - Any held word is lost.

## Timing
- Latency: a word accepted at edge e with no hazard produces iss_valid during the cycle after edge e+1, i.e. 2 edges.
- Back-to-back independent words: one issue per cycle.
- Dependent pair (B reads A.rd): exactly WB_LAT bubble cycles between A's and B's iss_valid cycles.
- Dependency at distance k (1 ≤ k ≤ WB_LAT) gives WB_LAT−k+1 bubbles. At distance > WB_LAT there are none.
- in_valid with in_ready=0: the upstream must hold the word stable. The block samples nothing from in_instr.
- Simultaneous leave and accept in one cycle is legal. The hold register is refilled in the same edge.

## Structure
- Package alu_pkg holds:
  - func code localparams (ADD=0 … SHL=11) and FUNC_MAX=11;
  - instruction field bit positions and the instruction width of 24;
  - the register index width of 4 and the address width of 8.
- The same package is shared with the ALU pipeline.
- Sub-module alu_scoreboard (WB_LAT, push_v, push_rd, rs1, rs2 → hit) holds the shift register and the comparators.
- The top level holds the hold register, the issue register and the counters.

## Test plan
- Independent stream: ADD r1←r2,r3, then SUB r4←r5,r6, then XOR r7←r8,r9 on consecutive cycles → iss_valid high 3 consecutive cycles; fields match; stall_cnt=0.
- RAW distance 1, WB_LAT=2: ADD r1←r2,r3, then OR r5←r1,r4 → 2 bubble cycles between issues; stall_cnt=2; in_ready low during the stall.
- RAW distance 2: ADD r1, then AND r6←r7,r8, then SUB r9←r1,r2 → 1 bubble before SUB; stall_cnt=1.
- Illegal word func=13 between two legal words → illegal pulses once, illegal_cnt=1, no iss_valid for it; neighbours issue normally.
- Reset asserted during a stall (hold holding a dependent word) → next cycle: iss_valid=0, in_ready=1, counters 0. The first word after reset issues with no stall even if it reads the pre-reset rd.
- Saturation: force 65 540 stall cycles (one producer followed by a dependent word held by a repeated hazard loop) → stall_cnt stays at 65 535.
